// File: rtl/byte_ram_responder_pkg.sv
// Shared definitions for the byte-serial RAM bus responder: IO window map
// and the read/write flag encoding used by the memory controller.
package byte_ram_responder_pkg;

    // IO window base and register offsets within it
    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [15:0] IO_TX_OFS   = 16'h0000;
    localparam logic [15:0] IO_STAT_OFS = 16'h0004;
    localparam logic [15:0] IO_HALT_OFS = 16'h0008;

    // Bus direction flag, shared with the controller
    typedef enum logic {
        Read  = 1'b0,
        Write = 1'b1
    } rw_e;

    // Only address bits [17:16] select the IO window; higher bits alias.
    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_BASE[17:16];
    endfunction

endpackage

// File: rtl/byte_ram_responder_io_tx_fifo.sv
// Circular byte FIFO feeding the IO output stream. Head is shown
// combinationally; pushes land the cycle after (no empty bypass).
module byte_ram_responder_io_tx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [7:0]                 din_i,
    input  logic                       pop_i,
    output logic [7:0]                 head_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       drop_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // A full FIFO still accepts a push when the head leaves the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    // Occupancy next-state
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Pointer and count registers; pointers wrap at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Storage has no reset; the caller gates push during reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/byte_ram_responder.sv
// Memory-side responder for the byte-serial RAM bus: main RAM plus the IO
// window (output FIFO, status, halt). Read data is registered, 1-cycle latency.
// Optional feature macro: RAM_WRITE_PROTECT_EN (reject RAM writes below RO_LIMIT).
module byte_ram_responder
    import byte_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] RO_LIMIT   = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ram_a,
    input  logic [7:0]  ram_din,
    input  logic        ram_wr,
    output logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        io_ovf,
    output logic        halt,
    output logic [15:0] wp_cnt
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]        ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic [15:0]       ofs;
    logic              io_sel, is_wr, io_wr;
    logic              ram_we_req, wp_block, ram_commit;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_drop;
    logic [7:0]        fifo_head;
    logic [CntW-1:0]   fifo_count;
    logic [31:0]       cnt_wide;
    logic [4:0]        cnt_sat;
    logic [7:0]        rdata_d, ram_dout_q;
    logic              io_ovf_q, halt_q;

    assign io_sel     = is_io(ram_a);
    assign idx        = ram_a[ADDR_W-1:0];
    assign ofs        = ram_a[15:0];
    assign is_wr      = (ram_wr == Write);
    assign io_wr      = is_wr && io_sel;
    assign ram_we_req = is_wr && !io_sel;
    assign ram_commit = ram_we_req && !wp_block;

    // IO side effects are discarded during reset
    assign fifo_push = !rst && io_wr && (ofs == IO_TX_OFS);
    assign fifo_pop  = tx_valid && tx_ready;

    byte_ram_responder_io_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_io_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (ram_din),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop),
        .count_o (fifo_count)
    );

    assign tx_data  = fifo_head;
    assign tx_valid = !fifo_empty;
    assign io_ovf   = io_ovf_q;
    assign halt     = halt_q;
    assign ram_dout = ram_dout_q;

`ifdef RAM_WRITE_PROTECT_EN
    logic [15:0] wp_cnt_q;

    assign wp_block = (ram_a < RO_LIMIT);
    assign wp_cnt   = wp_cnt_q;

    // Count rejected RAM writes, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_cnt_q <= '0;
        end else if (ram_we_req && wp_block && (wp_cnt_q != 16'hFFFF)) begin
            wp_cnt_q <= wp_cnt_q + 16'd1;
        end
    end
`else
    logic unused_cfg;

    assign wp_block   = 1'b0;
    assign wp_cnt     = '0;
    assign unused_cfg = ^{RO_LIMIT, ram_a[31:18], fifo_full};
`endif

    // Status count field saturates at 31 for deep FIFOs
    always_comb begin
        cnt_wide = 32'(fifo_count);
        cnt_sat  = (cnt_wide > 32'd31) ? 5'd31 : cnt_wide[4:0];
    end

    // Read mux; writes return 0
    always_comb begin
        rdata_d = '0;
        if (!is_wr) begin
            if (!io_sel) begin
                rdata_d = ram_q[idx];
            end else begin
                case (ofs)
                    IO_TX_OFS:   rdata_d = fifo_head;
                    IO_STAT_OFS: rdata_d = {io_ovf_q, halt_q, 1'b0, cnt_sat};
                    default:     rdata_d = '0;
                endcase
            end
        end
    end

    // RAM array; writes commit even during reset, contents never cleared
    always_ff @(posedge clk) begin
        if (ram_commit) ram_q[idx] <= ram_din;
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (rst) ram_dout_q <= '0;
        else     ram_dout_q <= rdata_d;
    end

    // Sticky overflow and halt flags
    always_ff @(posedge clk) begin
        if (rst) begin
            io_ovf_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            if (fifo_drop) begin
                io_ovf_q <= 1'b1;
            end else if (io_wr && (ofs == IO_STAT_OFS)) begin
                io_ovf_q <= 1'b0;
            end
            if (io_wr && (ofs == IO_HALT_OFS)) halt_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_byte_ram_responder.sv
// Scoreboard bench for byte_ram_responder: the driver computes expected
// post-edge outputs from a queue/array model and the monitor compares them.
module tb_byte_ram_responder;

    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] RO_LIMIT   = 32'h0000_1000;
    localparam logic [31:0] IO_TX      = 32'h0003_0000;
    localparam logic [31:0] IO_STAT    = 32'h0003_0004;
    localparam logic [31:0] IO_HALT    = 32'h0003_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ram_a = '0;
    logic [7:0]  ram_din = '0;
    logic        ram_wr = 1'b0;
    logic [7:0]  ram_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        io_ovf;
    logic        halt;
    logic [15:0] wp_cnt;

    byte_ram_responder #(
        .ADDR_W     (17),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RO_LIMIT   (RO_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ram_a    (ram_a),
        .ram_din  (ram_din),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .io_ovf   (io_ovf),
        .halt     (halt),
        .wp_cnt   (wp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  dout;
        logic        chk;
        logic        tv;
        logic [7:0]  td;
        logic        ovf;
        logic        hlt;
        logic [15:0] wp;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    // Reference model state
    logic [7:0] mref [int];
    logic [7:0] mfifo[$];
    logic       m_ovf = 1'b0;
    logic       m_halt = 1'b0;
    int         m_wp = 0;

    task automatic check(input string name, input int id, input logic [15:0] act,
                         input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s access %0d: got %0h expected %0h", name, id, act, expv);
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [7:0] d, input logic wr,
                          input logic rdy, input logic r);
        exp_t        e;
        logic        io;
        logic [15:0] ofs;
        int          idx;
        int          sz;
        logic        prot;
        logic        pop;
        @(negedge clk);
        rst      = r;
        ram_a    = a;
        ram_din  = d;
        ram_wr   = wr;
        tx_ready = rdy;

        io   = (a[17:16] == 2'b11);
        ofs  = a[15:0];
        idx  = int'(a[16:0]);
`ifdef RAM_WRITE_PROTECT_EN
        prot = (a < RO_LIMIT);
`else
        prot = 1'b0;
`endif
        pop    = (mfifo.size() > 0) && rdy;
        e      = '0;
        e.id   = next_id;
        next_id++;

        if (wr && !io) begin
            e.chk = 1'b1;
            if (!prot) mref[idx] = d;
            else if (m_wp < 65535) m_wp++;
        end

        if (r) begin
            e.chk = 1'b1;
            e.dout = 8'h00;
            mfifo.delete();
            m_ovf  = 1'b0;
            m_halt = 1'b0;
            m_wp   = 0;
        end else begin
            if (!wr) begin
                if (!io) begin
                    if (mref.exists(idx)) begin
                        e.chk = 1'b1;
                        e.dout = mref[idx];
                    end
                end else if (ofs == 16'h0) begin
                    if (mfifo.size() > 0) begin
                        e.chk = 1'b1;
                        e.dout = mfifo[0];
                    end
                end else if (ofs == 16'h4) begin
                    sz = (mfifo.size() > 31) ? 31 : mfifo.size();
                    e.chk = 1'b1;
                    e.dout = {m_ovf, m_halt, 1'b0, 5'(sz)};
                end else begin
                    e.chk = 1'b1;
                    e.dout = 8'h00;
                end
            end
            if (pop) void'(mfifo.pop_front());
            if (wr && io) begin
                if (ofs == 16'h0) begin
                    if (mfifo.size() < FIFO_DEPTH) mfifo.push_back(d);
                    else m_ovf = 1'b1;
                end else if (ofs == 16'h4) begin
                    m_ovf = 1'b0;
                end else if (ofs == 16'h8) begin
                    m_halt = 1'b1;
                end
            end
        end

        e.tv  = (mfifo.size() > 0);
        e.td  = (mfifo.size() > 0) ? mfifo[0] : 8'h00;
        e.ovf = m_ovf;
        e.hlt = m_halt;
        e.wp  = 16'(m_wp);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: one expected entry per edge, sampled just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk) check("ram_dout", e.id, {8'h00, ram_dout}, {8'h00, e.dout});
                check("tx_valid", e.id, {15'h0, tx_valid}, {15'h0, e.tv});
                if (e.tv) check("tx_data", e.id, {8'h00, tx_data}, {8'h00, e.td});
                check("io_ovf", e.id, {15'h0, io_ovf}, {15'h0, e.ovf});
                check("halt", e.id, {15'h0, halt}, {15'h0, e.hlt});
                check("wp_cnt", e.id, wp_cnt, e.wp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  wbytes [4];
        int          sel;
        wbytes[0] = 8'hEF; wbytes[1] = 8'hBE; wbytes[2] = 8'hAD; wbytes[3] = 8'hDE;

        // Reset
        access(32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
        access(32'h0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Write then read back next cycle
        access(32'h10, 8'hAB, 1'b1, 1'b0, 1'b0);
        access(32'h10, 8'h00, 1'b0, 1'b0, 1'b0);

        // 4-byte store then 4-byte load
        for (int i = 0; i < 4; i++) access(32'h100 + i, wbytes[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) access(32'h100 + i, 8'h00, 1'b0, 1'b0, 1'b0);

        // Overfill the FIFO, read status, clear overflow
        for (int i = 0; i < 9; i++) access(IO_TX, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
        access(IO_STAT, 8'h00, 1'b0, 1'b0, 1'b0);
        access(IO_STAT, 8'h00, 1'b1, 1'b0, 1'b0);
        access(IO_STAT, 8'h00, 1'b0, 1'b0, 1'b0);

        // Full FIFO: pop and push in the same cycle, then drain
        access(IO_TX, 8'h55, 1'b1, 1'b1, 1'b0);
        access(IO_STAT, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) access(IO_TX, 8'h00, 1'b0, 1'b1, 1'b0);

        // Halt, further traffic, reset mid-read
        access(32'h20, 8'h5A, 1'b1, 1'b0, 1'b0);
        access(IO_HALT, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) access(IO_TX, 8'(i), 1'b1, 1'b0, 1'b0);
        access(32'h20, 8'h00, 1'b0, 1'b0, 1'b0);
        access(IO_STAT, 8'h00, 1'b0, 1'b0, 1'b0);
        access(32'h20, 8'h00, 1'b0, 1'b0, 1'b1);
        access(32'h20, 8'h00, 1'b0, 1'b0, 1'b0);

        // Write during reset is still committed; IO push during reset is not
        access(32'h40, 8'h66, 1'b1, 1'b0, 1'b1);
        access(IO_TX, 8'h99, 1'b1, 1'b0, 1'b1);
        access(32'h40, 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef RAM_WRITE_PROTECT_EN
        access(32'h0, 8'h77, 1'b1, 1'b0, 1'b0);
        access(32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        access(32'h2000, 8'h77, 1'b1, 1'b0, 1'b0);
        access(32'h2000, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized traffic with address aliasing
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) begin
                case ($urandom_range(0, 7))
                    0, 1, 2: a = IO_TX;
                    3, 4:    a = IO_STAT;
                    5:       a = IO_HALT;
                    default: a = IO_BASE_PLUS_C();
                endcase
            end else begin
                a = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 1) == 1) a = a + 32'h1FF00;
                if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
            end
            a = a + ($urandom_range(0, 7) << 18);
            access(a, 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 99) == 0));
        end

        access(32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [31:0] IO_BASE_PLUS_C();
        return 32'h0003_000C;
    endfunction

endmodule
